// File: rtl/rx_handshake_arb.sv
// rx_handshake_arb: terminates NUM_CH RX Valid/Ready links, round-robin
// arbitrates the requesting channels and hands one registered word per cycle
// to the router core, with a per-channel stuck-Valid timeout.

// Per-channel handshake FSM (INIT -> READY -> DONE) with stuck-Valid timeout.
module rx_hs_ch #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic valid_i,
   input  logic grant_i,
   output logic req_o,
   output logic ready_o,
   output logic timeout_o
);

   typedef enum logic [1:0] {ST_INIT, ST_READY, ST_DONE} st_e;

   st_e             state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            ready_q, ready_d;
   logic            to_q, to_d;

   // A channel only asks for arbitration once it is READY and its unit has a word.
   assign req_o     = (state_q == ST_READY) && valid_i;
   assign ready_o   = ready_q;
   assign timeout_o = to_q;

   // State, counter and registered outputs; reset wins over any grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         to_q    <= to_d;
      end
   end

   // Next state; Ready and the timeout pulse are decoded from the next state
   // so they appear in the cycle right after the deciding edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      to_d    = 1'b0;
      case (state_q)
         // Out of reset or after a timeout: wait for Valid low so a stale
         // word is never taken.
         ST_INIT: begin
            if (!valid_i) state_d = ST_READY;
         end
         ST_READY: begin
            if (grant_i) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end
         end
         ST_DONE: begin
            if (!valid_i) begin
               state_d = ST_READY;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + TO_W'(1);
               if (cnt_d == TO_W'(TIMEOUT)) begin
                  to_d    = 1'b1;
                  state_d = ST_INIT;
               end
            end
         end
         default: state_d = ST_INIT;
      endcase
      ready_d = (state_d == ST_READY);
   end

endmodule

// Top: channel FSM array, round-robin winner select, registered core output.
module rx_handshake_arb #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 8,
   parameter int CH_W    = 2,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        RX_Data_Valid,
   input  logic [NUM_CH*DATA_W-1:0] RX_Data,
   output logic [NUM_CH-1:0]        RX_Data_Ready,
   input  logic                     rc_ready,
   output logic                     rx_has_data,
   output logic [DATA_W-1:0]        rx_data,
   output logic [CH_W-1:0]          rx_chan,
   output logic [NUM_CH-1:0]        rx_timeout_err
);

   logic [NUM_CH-1:0]              req;
   logic [NUM_CH-1:0]              gnt_oh;
   logic                           gnt_vld;
   logic [CH_W-1:0]                gnt_idx;
   logic [CH_W-1:0]                idx;
   logic [NUM_CH-1:0][DATA_W-1:0]  data_arr;

   logic                           has_q, has_d;
   logic [DATA_W-1:0]              data_q, data_d;
   logic [CH_W-1:0]                chan_q, chan_d;
   logic [CH_W-1:0]                last_q, last_d;

   assign data_arr    = RX_Data;
   assign rx_has_data = has_q;
   assign rx_data     = data_q;
   assign rx_chan     = chan_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      rx_hs_ch #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .valid_i   (RX_Data_Valid[c]),
         .grant_i   (gnt_oh[c]),
         .req_o     (req[c]),
         .ready_o   (RX_Data_Ready[c]),
         .timeout_o (rx_timeout_err[c])
      );
   end

   // Round-robin pick: first requester after the last winner, only when the
   // core can take a word.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      gnt_oh  = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = CH_W'((int'(last_q) + i) % NUM_CH);
         if (rc_ready && !gnt_vld && req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
      if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
   end

   // Output word/channel only change on a grant; the strobe marks that edge.
   always_comb begin
      has_d  = gnt_vld;
      data_d = data_q;
      chan_d = chan_q;
      last_d = last_q;
      if (gnt_vld) begin
         data_d = data_arr[gnt_idx];
         chan_d = gnt_idx;
         last_d = gnt_idx;
      end
   end

   // Core-side registers; the pointer starts at the top channel so channel 0
   // has first priority after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         has_q  <= 1'b0;
         data_q <= '0;
         chan_q <= '0;
         last_q <= CH_W'(NUM_CH - 1);
      end else begin
         has_q  <= has_d;
         data_q <= data_d;
         chan_q <= chan_d;
         last_q <= last_d;
      end
   end

endmodule

// File: tb/tb_rx_handshake_arb.sv
// Directed bench for rx_handshake_arb (4 channels, TIMEOUT=8).
module tb_rx_handshake_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  vld;
   logic [31:0] dat;
   logic [3:0]  rdy;
   logic        rc_ready;
   logic        has;
   logic [7:0]  rxd;
   logic [1:0]  chan;
   logic [3:0]  terr;

   int n_tests = 0;
   int n_fail  = 0;

   rx_handshake_arb #(
      .NUM_CH(4), .DATA_W(8), .CH_W(2), .TIMEOUT(8), .TO_W(8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .RX_Data_Valid  (vld),
      .RX_Data        (dat),
      .RX_Data_Ready  (rdy),
      .rc_ready       (rc_ready),
      .rx_has_data    (has),
      .rx_data        (rxd),
      .rx_chan        (chan),
      .rx_timeout_err (terr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle; outputs then reflect that edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe and word check in one call.
   task automatic chk_out(input string tag, input logic h, input logic [7:0] d, input logic [1:0] c);
      chk({tag, ".has"}, 32'(has), 32'(h));
      chk({tag, ".data"}, 32'(rxd), 32'(d));
      chk({tag, ".chan"}, 32'(chan), 32'(c));
   endtask

   initial begin
      // Reset with a stale Valid on channel 1.
      rst = 1'b1; vld = 4'b0010; rc_ready = 1'b1; dat = 32'h0;
      tick(); tick();
      chk("rst.rdy", 32'(rdy), 32'h0);
      chk_out("rst", 1'b0, 8'h00, 2'd0);
      chk("rst.err", 32'(terr), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stale.rdy", 32'(rdy), 32'b1101);
         chk("stale.has", 32'(has), 32'h0);
      end
      vld = 4'b0000;
      tick();
      chk("stale.rdy_up", 32'(rdy), 32'b1111);
      chk("stale.has2", 32'(has), 32'h0);

      // Single word on channel 2; later data changes are ignored.
      dat = {8'h00, 8'hA5, 8'h00, 8'h00}; vld = 4'b0100;
      tick();
      chk_out("ch2", 1'b1, 8'hA5, 2'd2);
      chk("ch2.rdy", 32'(rdy), 32'b1011);
      dat = {8'h00, 8'hFF, 8'h00, 8'h00};
      tick();
      chk_out("ch2.hold", 1'b0, 8'hA5, 2'd2);
      chk("ch2.rdy_hold", 32'(rdy), 32'b1011);
      vld = 4'b0000;
      tick();
      chk("ch2.rdy_back", 32'(rdy), 32'b1111);

      // Fresh reset, then all four channels at once: 0,1,2,3 back to back.
      rst = 1'b1; tick(); rst = 1'b0; tick();
      dat = {8'h13, 8'h12, 8'h11, 8'h10}; vld = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk_out("all", 1'b1, 8'(8'h10 + c), 2'(c));
      end
      tick();
      chk("all.5th_has", 32'(has), 32'h0);
      chk("all.rdy", 32'(rdy), 32'b0000);
      vld = 4'b0000;
      tick();
      chk("all.rdy_back", 32'(rdy), 32'b1111);

      // Round robin: after ch1 wins, ch0 and ch3 request -> ch3 then ch0.
      vld = 4'b0010;
      tick();
      chk_out("rr.ch1", 1'b1, 8'h11, 2'd1);
      vld = 4'b0000;
      tick();
      vld = 4'b1001;
      tick();
      chk_out("rr.first", 1'b1, 8'h13, 2'd3);
      tick();
      chk_out("rr.second", 1'b1, 8'h10, 2'd0);
      tick();
      chk("rr.idle", 32'(has), 32'h0);
      vld = 4'b0000;
      tick();

      // Core not ready: requester waits with Ready high, then wins.
      rc_ready = 1'b0; vld = 4'b0010;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall.has", 32'(has), 32'h0);
         chk("stall.rdy", 32'(rdy), 32'b1111);
      end
      rc_ready = 1'b1;
      tick();
      chk_out("stall.go", 1'b1, 8'h11, 2'd1);
      vld = 4'b0000;
      tick();

      // Timeout: ch0 held Valid after grant, pulse 8 edges after DONE entry.
      vld = 4'b0001;
      tick();
      chk_out("to.gnt", 1'b1, 8'h10, 2'd0);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("to.wait_err", 32'(terr), 32'h0);
         chk("to.wait_rdy", 32'(rdy[0]), 32'h0);
      end
      tick();
      chk("to.pulse", 32'(terr), 32'b0001);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("to.after_err", 32'(terr), 32'h0);
         chk("to.after_rdy", 32'(rdy[0]), 32'h0);
         chk("to.after_has", 32'(has), 32'h0);
      end
      vld = 4'b0000;
      tick();
      chk("to.rdy_back", 32'(rdy[0]), 32'h1);

      // Reset on a grant edge: grant discarded, everything cleared.
      vld = 4'b0100; rst = 1'b1;
      tick();
      chk("rstg.rdy", 32'(rdy), 32'h0);
      chk_out("rstg", 1'b0, 8'h00, 2'd0);
      chk("rstg.err", 32'(terr), 32'h0);
      rst = 1'b0; vld = 4'b0000;
      tick();
      chk("rstg.no_strobe", 32'(has), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
